muldiv_unit: RTL and testbench

- Iterative multiply/divide unit directly downstream of the register file: consumes the rs/rt operand values read out of the register file and computes MIPS MULT/MULTU/DIV/DIVU results into private HI/LO registers.
- Executes one radix-2 step per cycle (shift-add multiply, restoring divide), with a start/busy/done handshake towards the control unit.
- HI/LO are read back by MFHI/MFLO and written directly by MTHI/MTLO.

---
 rtl/muldiv_unit.sv | 168 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 MULT/MULTU/DIV/DIVU engine with private HI/LO registers.
// Define MULDIV_SIGNED_EN for two's-complement MULT/DIV; otherwise they behave as MULTU/DIVU.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   operand;
    logic               is_div;
    logic               by_zero;
    logic               neg_q;
    logic               neg_r;
    logic               signed_op;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [WIDTH-1:0]   step_hi;
    logic [WIDTH-1:0]   step_lo;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

`ifdef MULDIV_SIGNED_EN
    assign signed_op = ~op[0];
`else
    logic unused_op;
    assign signed_op = 1'b0;
    assign unused_op = op[0];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (cnt == '0) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // Operands are iterated as magnitudes; result signs are re-applied in FIX.
    always_comb begin
        abs_a = (signed_op && rs_data[WIDTH-1]) ? -rs_data : rs_data;
        abs_b = (signed_op && rt_data[WIDTH-1]) ? -rt_data : rt_data;
    end

    // One radix-2 step: {acc_hi,acc_lo} is the product shifter for multiply,
    // and the remainder / dividend-quotient shifter for restoring divide.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, operand};
        if (is_div) begin
            if (!div_diff[WIDTH]) begin
                step_hi = div_diff[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = div_shift[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod_fix = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        quot_fix = neg_q ? -acc_lo : acc_lo;
        rem_fix  = neg_r ? -acc_hi : acc_hi;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            operand <= '0;
            is_div  <= 1'b0;
            by_zero <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
            div0    <= 1'b0;
        end else begin
            done <= 1'b0;
            div0 <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        cnt     <= CW'(WIDTH - 1);
                        is_div  <= op[1];
                        by_zero <= op[1] && (rt_data == '0);
                        neg_r   <= signed_op && rs_data[WIDTH-1];
                        neg_q   <= signed_op && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                        acc_hi  <= '0;
                        acc_lo  <= op[1] ? abs_a : abs_b;
                        operand <= op[1] ? abs_b : abs_a;
                    end
                end
                CALC: begin
                    cnt    <= cnt - CW'(1);
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                end
                FIX: begin
                    done <= 1'b1;
                    div0 <= by_zero;
                    // Divide by zero leaves the dividend in acc_hi, so rem_fix restores rs_data.
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= by_zero ? '1 : quot_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with hand-computed HI/LO results for muldiv_unit.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div0;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors = 0;
    int errors  = 0;

`ifdef MULDIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    muldiv_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .div0    (div0),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Called at a negedge; presents the request for the next rising edge (E0).
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input logic hw, input logic lw, input logic [31:0] wd);
        start   = 1'b1;
        op      = o;
        rs_data = a;
        rt_data = b;
        hi_we   = hw;
        lo_we   = lw;
        wdata   = wd;
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        checkOutput("busy_after_start", 64'(busy), 64'd1);
        checkOutput("done_low_after_start", 64'(done), 64'd0);
    endtask

    task automatic waitDone(input string tag, input int already);
        int lat;
        lat = already;
        while (done !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, "_latency"}, 64'(lat), 64'd33);
        checkOutput({tag, "_busy_with_done"}, 64'(busy), 64'd0);
    endtask

    task automatic runVector(input string tag, input logic [1:0] o, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp_hi,
                             input logic [31:0] exp_lo, input logic exp_div0);
        applyStimulus(o, a, b, 1'b0, 1'b0, 32'h0);
        waitDone(tag, 0);
        checkOutput({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        checkOutput({tag, "_lo"}, 64'(lo), 64'(exp_lo));
        checkOutput({tag, "_div0"}, 64'(div0), 64'(exp_div0));
    endtask

    initial begin
        int pulses;
        rst_n   = 1'b0;
        start   = 1'b0;
        op      = 2'b00;
        rs_data = '0;
        rt_data = '0;
        hi_we   = 1'b0;
        lo_we   = 1'b0;
        wdata   = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_div0", 64'(div0), 64'd0);
        checkOutput("reset_hi", 64'(hi), 64'd0);
        checkOutput("reset_lo", 64'(lo), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Each vector starts in the cycle where the previous done is high.
        runVector("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        runVector("mult_neg3x7", 2'b00, 32'hFFFFFFFD, 32'h00000007,
                  SIGNED_EN ? 32'hFFFFFFFF : 32'h00000006, 32'hFFFFFFEB, 1'b0);
        runVector("mult_minxmin", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
        runVector("divu_100_7", 2'b11, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 1'b0);
        runVector("div_neg7_2", 2'b10, 32'hFFFFFFF9, 32'h00000002,
                  SIGNED_EN ? 32'hFFFFFFFF : 32'h00000001,
                  SIGNED_EN ? 32'hFFFFFFFD : 32'h7FFFFFFC, 1'b0);
        runVector("div_7_neg2", 2'b10, 32'h00000007, 32'hFFFFFFFE,
                  SIGNED_EN ? 32'h00000001 : 32'h00000007,
                  SIGNED_EN ? 32'hFFFFFFFD : 32'h00000000, 1'b0);
        runVector("div_min_neg1", 2'b10, 32'h80000000, 32'hFFFFFFFF,
                  SIGNED_EN ? 32'h00000000 : 32'h80000000,
                  SIGNED_EN ? 32'h80000000 : 32'h00000000, 1'b0);
        runVector("divu_by_zero", 2'b11, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b1);
        runVector("div_neg_by_zero", 2'b10, 32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1);

        @(negedge clk);
        checkOutput("done_single_pulse", 64'(done), 64'd0);
        checkOutput("div0_single_pulse", 64'(div0), 64'd0);

        // MTHI on the accepting edge lands first, then the result overwrites it.
        applyStimulus(2'b01, 32'd2, 32'd3, 1'b1, 1'b0, 32'hDEADBEEF);
        checkOutput("mthi_with_start", 64'(hi), 64'hDEADBEEF);
        waitDone("multu_after_mthi", 0);
        checkOutput("multu_after_mthi_hi", 64'(hi), 64'd0);
        checkOutput("multu_after_mthi_lo", 64'(lo), 64'd6);

        // Second start and MTHI at E10 of a running MULTU are both ignored.
        applyStimulus(2'b01, 32'd3, 32'd5, 1'b0, 1'b0, 32'h0);
        repeat (9) @(negedge clk);
        start   = 1'b1;
        op      = 2'b11;
        rs_data = 32'd99;
        rt_data = 32'd1;
        hi_we   = 1'b1;
        wdata   = 32'hAAAAAAAA;
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        checkOutput("busy_ignored_hi", 64'(hi), 64'd0);
        waitDone("multu_3x5", 10);
        checkOutput("multu_3x5_hi", 64'(hi), 64'd0);
        checkOutput("multu_3x5_lo", 64'(lo), 64'd15);

        lo_we = 1'b1;
        wdata = 32'h00000055;
        @(negedge clk);
        lo_we = 1'b0;
        checkOutput("mtlo_idle_lo", 64'(lo), 64'h55);
        checkOutput("mtlo_idle_hi", 64'(hi), 64'd0);

        // Reset at E20 of a DIVU aborts it without any result write.
        applyStimulus(2'b11, 32'd1000, 32'd3, 1'b0, 1'b0, 32'h0);
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_hi", 64'(hi), 64'd0);
        checkOutput("abort_lo", 64'(lo), 64'd0);
        pulses = 0;
        repeat (50) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        checkOutput("abort_no_done", 64'(pulses), 64'd0);

        runVector("divu_after_reset", 2'b11, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
